// File: rtl/program_loader.sv
// Program loader: packs a byte stream into big-endian words, writes them to
// main memory while holding the core in reset, then hands the memory port over.
module program_loader #(
   parameter int unsigned MEM_BYTES   = 1024,
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ld_start,
   input  logic        ld_valid,
   input  logic [7:0]  ld_byte,
   input  logic        ld_last,
   output logic        ld_ready,
   input  logic        core_mem_en,
   input  logic        core_wen,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   output logic        mem_en,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        core_reset,
   output logic        ld_error,
   output logic [15:0] words_loaded
);

   localparam int unsigned HCW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_HOLD,
      S_RUN,
      S_ERROR
   } state_e;

   state_e          state_q, state_d;
   logic [31:0]     buf_q, buf_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [31:0]     addr_q, addr_d;
   logic [15:0]     words_q, words_d;
   logic            err_q, err_d;
   logic            wr_q, wr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [HCW-1:0]  hold_q, hold_d;
   logic            core_reset_q, core_reset_d;

   logic [31:0]     shifted;
   logic [31:0]     padded;
   logic            addr_ok;
   logic            write_now;

   // State and datapath registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         buf_q        <= '0;
         cnt_q        <= '0;
         addr_q       <= '0;
         words_q      <= '0;
         err_q        <= 1'b0;
         wr_q         <= 1'b0;
         wdata_q      <= '0;
         hold_q       <= '0;
         core_reset_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         words_q      <= words_d;
         err_q        <= err_d;
         wr_q         <= wr_d;
         wdata_q      <= wdata_d;
         hold_q       <= hold_d;
         core_reset_q <= core_reset_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d   = state_q;
      buf_d     = buf_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      words_d   = words_q;
      err_d     = err_q;
      wr_d      = wr_q;
      wdata_d   = wdata_q;
      hold_d    = hold_q;
      ld_ready  = 1'b0;
      mem_en    = 1'b0;
      mem_wen   = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;

      shifted = {buf_q[23:0], ld_byte};
      case (cnt_q)
         2'd0:    padded = {ld_byte, 24'h0};
         2'd1:    padded = {buf_q[7:0], ld_byte, 16'h0};
         2'd2:    padded = {buf_q[15:0], ld_byte, 8'h0};
         default: padded = shifted;
      endcase

      addr_ok   = (addr_q < MEM_LIMIT);
      write_now = ((state_q == S_LOAD) && wr_q) || (state_q == S_FLUSH);

      // Out-of-range writes never reach memory
      if (write_now && addr_ok) begin
         mem_en    = 1'b1;
         mem_wen   = 1'b1;
         mem_addr  = addr_q;
         mem_wdata = wdata_q;
      end

      case (state_q)
         S_LOAD: begin
            ld_ready = 1'b1;
            if (wr_q) begin
               wr_d = 1'b0;
               if (addr_ok) begin
                  addr_d  = addr_q + 32'd4;
                  words_d = words_q + 16'd1;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_ERROR;
               end
            end
            if (ld_valid && !(wr_q && !addr_ok)) begin
               if (ld_last) begin
                  // Final word, full or partial, is written from FLUSH
                  wdata_d = padded;
                  buf_d   = '0;
                  cnt_d   = '0;
                  state_d = S_FLUSH;
               end else if (cnt_q == 2'd3) begin
                  wdata_d = shifted;
                  wr_d    = 1'b1;
                  buf_d   = '0;
                  cnt_d   = '0;
               end else begin
                  buf_d = shifted;
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end
         S_FLUSH: begin
            hold_d = '0;
            if (addr_ok) begin
               addr_d  = addr_q + 32'd4;
               words_d = words_q + 16'd1;
               state_d = S_HOLD;
            end else begin
               err_d   = 1'b1;
               state_d = S_ERROR;
            end
         end
         S_HOLD: begin
            if (hold_q == HOLD_LAST) begin
               state_d = S_RUN;
            end else begin
               hold_d = hold_q + HCW'(1);
            end
         end
         S_RUN: begin
            mem_en    = core_mem_en;
            mem_wen   = core_wen;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
         end
         default: ;
      endcase

      // A start pulse restarts from any state and discards a coincident byte
      if (ld_start) begin
         state_d = S_LOAD;
         buf_d   = '0;
         cnt_d   = '0;
         addr_d  = '0;
         words_d = '0;
         err_d   = 1'b0;
         wr_d    = 1'b0;
         hold_d  = '0;
      end

      core_reset_d = (state_d != S_RUN);
   end

   assign core_reset   = core_reset_q;
   assign ld_error     = err_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: vector table of byte streams with a
// write scoreboard, plus hand sequences for overflow, pass-through and resets.
module tb_program_loader;

   localparam int unsigned HOLD = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        ld_start, ld_valid, ld_last;
   logic [7:0]  ld_byte;
   logic        ld_ready;
   logic        core_mem_en, core_wen;
   logic [31:0] core_addr, core_wdata;
   logic        mem_en, mem_wen;
   logic [31:0] mem_addr, mem_wdata;
   logic        core_reset, ld_error;
   logic [15:0] words_loaded;

   logic        sm_ld_ready, sm_mem_en, sm_mem_wen, sm_core_reset, sm_ld_error;
   logic [31:0] sm_mem_addr, sm_mem_wdata;
   logic [15:0] sm_words_loaded;

   int checks = 0;
   int errors = 0;
   int sm_writes = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct packed {
      logic [95:0] bytes;
      logic [95:0] words;
      int          n;
      int          nw;
      logic        gap;
   } vec_t;

   wr_t  exp_q[$];
   vec_t vecs[5];

   always #5 clock = ~clock;

   program_loader #(.MEM_BYTES(1024), .HOLD_CYCLES(HOLD)) dut (
      .clock(clock), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid),
      .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
      .core_mem_en(core_mem_en), .core_wen(core_wen), .core_addr(core_addr),
      .core_wdata(core_wdata), .mem_en(mem_en), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_reset(core_reset),
      .ld_error(ld_error), .words_loaded(words_loaded)
   );

   program_loader #(.MEM_BYTES(8), .HOLD_CYCLES(HOLD)) dut_small (
      .clock(clock), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid),
      .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(sm_ld_ready),
      .core_mem_en(core_mem_en), .core_wen(core_wen), .core_addr(core_addr),
      .core_wdata(core_wdata), .mem_en(sm_mem_en), .mem_wen(sm_mem_wen),
      .mem_addr(sm_mem_addr), .mem_wdata(sm_mem_wdata), .core_reset(sm_core_reset),
      .ld_error(sm_ld_error), .words_loaded(sm_words_loaded)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic pulse_start();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
   endtask

   task automatic drive_byte(input logic [7:0] b, input logic last);
      ld_valid = 1'b1;
      ld_byte  = b;
      ld_last  = last;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   // Drive a stream, pushing each word's expected write as its closing byte goes out
   task automatic send_stream(input logic [95:0] bytes, input int n,
                              input logic [95:0] words, input logic gap);
      for (int i = 0; i < n; i++) begin
         if (gap && i > 0) begin
            ld_valid = 1'b0;
            ld_last  = 1'b1;
            ld_byte  = 8'hFF;
            tick();
         end
         if ((i % 4 == 3) || (i == n - 1))
            push_exp(32'(4 * (i / 4)), words[95 - 32 * (i / 4) -: 32]);
         drive_byte(bytes[95 - 8 * i -: 8], 1'(i == n - 1));
      end
   endtask

   task automatic finish_check(input int nw);
      chk("final_write_cycle", 32'(mem_en), 32'd1);
      for (int k = 0; k < int'(HOLD); k++) begin
         tick();
         chk("hold_core_reset", 32'(core_reset), 32'd1);
         chk("hold_mem_en", 32'(mem_en), 32'd0);
      end
      tick();
      chk("run_core_reset", 32'(core_reset), 32'd0);
      chk("words_loaded", 32'(words_loaded), 32'(nw));
      chk("ld_error_clear", 32'(ld_error), 32'd0);
      chk("run_ld_ready", 32'(ld_ready), 32'd0);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic monitor();
      wr_t e;
      forever begin
         @(negedge clock);
         if (!reset && mem_en && core_reset) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got write %08h@%08h, expected none", mem_wdata, mem_addr);
            end else begin
               e = exp_q.pop_front();
               chk("write_addr", mem_addr, e.addr);
               chk("write_data", mem_wdata, e.data);
               chk("write_wen", 32'(mem_wen), 32'd1);
            end
         end
         if (!reset && sm_mem_en && sm_core_reset) begin
            sm_writes++;
            chk("small_addr_in_range", 32'(sm_mem_addr < 32'd8), 32'd1);
            chk("small_wdata", sm_mem_wdata, mem_wdata);
            chk("small_wen", 32'(sm_mem_wen), 32'd1);
         end
      end
   endtask

   initial begin
      int sm_base;
      reset = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = 8'h00;
      core_mem_en = 1'b0; core_wen = 1'b0; core_addr = '0; core_wdata = '0;

      vecs[0] = '{bytes: {64'h00000000_05028293, 32'h0}, words: {32'h00000000, 32'h05028293, 32'h0},
                  n: 8, nw: 2, gap: 1'b0};
      vecs[1] = '{bytes: {24'h014282, 72'h0}, words: {32'h01428200, 64'h0},
                  n: 3, nw: 1, gap: 1'b1};
      vecs[2] = '{bytes: {8'hAA, 88'h0}, words: {32'hAA000000, 64'h0},
                  n: 1, nw: 1, gap: 1'b0};
      vecs[3] = '{bytes: {48'h112233445566, 48'h0}, words: {32'h11223344, 32'h55660000, 32'h0},
                  n: 6, nw: 2, gap: 1'b0};
      vecs[4] = '{bytes: 96'hDEADBEEF_CAFEBABE_12345678, words: 96'hDEADBEEF_CAFEBABE_12345678,
                  n: 12, nw: 3, gap: 1'b1};

      fork
         monitor();
      join_none

      // Reset values
      #12;
      chk("rst_core_reset", 32'(core_reset), 32'd1);
      chk("rst_ld_ready", 32'(ld_ready), 32'd0);
      chk("rst_mem_en_wen", 32'({mem_en, mem_wen}), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_err_words", 32'({ld_error, words_loaded}), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      chk("idle_core_reset", 32'(core_reset), 32'd1);
      chk("idle_ld_ready", 32'(ld_ready), 32'd0);

      // Table-driven loads
      for (int v = 0; v < 5; v++) begin
         pulse_start();
         chk("load_ld_ready", 32'(ld_ready), 32'd1);
         chk("load_words_cleared", 32'(words_loaded), 32'd0);
         send_stream(vecs[v].bytes, vecs[v].n, vecs[v].words, vecs[v].gap);
         finish_check(vecs[v].nw);
      end

      // Overflow on the 8-byte instance
      sm_base = sm_writes;
      pulse_start();
      send_stream(96'h01020304_05060708_090A0B0C, 12, 96'h01020304_05060708_090A0B0C, 1'b0);
      finish_check(3);
      repeat (3) tick();
      chk("ovf_ld_error", 32'(sm_ld_error), 32'd1);
      chk("ovf_core_reset", 32'(sm_core_reset), 32'd1);
      chk("ovf_ld_ready", 32'(sm_ld_ready), 32'd0);
      chk("ovf_words", 32'(sm_words_loaded), 32'd2);
      chk("ovf_write_count", 32'(sm_writes - sm_base), 32'd2);

      // RUN pass-through, then restart from RUN
      core_mem_en = 1'b1; core_wen = 1'b1; core_addr = 32'h150; core_wdata = 32'hB4;
      #1;
      chk("pass_mem_en", 32'(mem_en), 32'd1);
      chk("pass_mem_wen", 32'(mem_wen), 32'd1);
      chk("pass_mem_addr", mem_addr, 32'h150);
      chk("pass_mem_wdata", mem_wdata, 32'hB4);
      tick();
      pulse_start();
      chk("restart_core_reset", 32'(core_reset), 32'd1);
      chk("restart_mem_en", 32'(mem_en), 32'd0);
      chk("restart_ld_ready", 32'(ld_ready), 32'd1);
      core_mem_en = 1'b0; core_wen = 1'b0; core_addr = '0; core_wdata = '0;

      // Restart mid-load discards the buffer and the coincident byte
      drive_byte(8'hAB, 1'b0);
      drive_byte(8'hCD, 1'b0);
      ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'hEE;
      tick();
      ld_start = 1'b0; ld_valid = 1'b0;
      push_exp(32'd0, 32'hFEEDF00D);
      drive_byte(8'hFE, 1'b0);
      drive_byte(8'hED, 1'b0);
      drive_byte(8'hF0, 1'b0);
      drive_byte(8'h0D, 1'b0);
      tick();
      chk("restart_words", 32'(words_loaded), 32'd1);
      chk("restart_drained", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset after two bytes
      pulse_start();
      drive_byte(8'h11, 1'b0);
      drive_byte(8'h22, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("midrst_core_reset", 32'(core_reset), 32'd1);
      chk("midrst_ld_ready", 32'(ld_ready), 32'd0);
      chk("midrst_mem_en", 32'(mem_en), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // Start with a coincident valid byte in IDLE: byte must not be taken
      ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'h77;
      tick();
      ld_start = 1'b0; ld_valid = 1'b0;
      send_stream({32'h0DDBA115, 64'h0}, 4, {32'h0DDBA115, 64'h0}, 1'b1);
      finish_check(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
